// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader
// UART-loadable instruction memory for the IF stage of the 5-stage MIPS pipeline.
// A boot loader assembles a framed byte stream (SYNC, LEN_HI, LEN_LO, 4*N
// big-endian data bytes) into 32-bit words written from word 0 upward, while
// holding the CPU. Reads are combinational from the byte PC.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous active-low reset
//   Address      byte PC; word index = Address[ADDR_WIDTH+1:2]
//   Instruction  combinational instruction word (0 = nop when gated)
//   rx_data      received UART byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   cpu_hold     pipeline stall request (registered)
//   load_done    one-cycle pulse on successful load (registered)
//   load_error   sticky frame error flag (registered)
//   loaded_words word count of the last successful load (registered)
//
// Optional feature macro: IMEM_CHECKSUM_EN adds a trailing XOR checksum byte
// and the CHECK state.
module instruction_ram_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    output logic [31:0]           Instruction,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   loaded_words
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IMEM_CHECKSUM_EN
        S_CHECK  = 3'd4,
`endif
        S_DONE   = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [7:0]        len_hi, len_hi_n;
    logic [PW-1:0]     len, len_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [23:0]       word_sr, word_sr_n;
    logic              cpu_hold_n;
    logic              load_done_n;
    logic              load_error_n;
    logic [PW-1:0]     loaded_words_n;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
`endif

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem [DEPTH];

    logic [15:0]           frame_len;
    logic [PW-1:0]         ptr_inc;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  unused_addr_bits;

    assign frame_len = {len_hi, rx_data};
    assign ptr_inc   = ptr + PW'(1);

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            len_hi       <= 8'h00;
            len          <= '0;
            ptr          <= '0;
            byte_idx     <= 2'd0;
            word_sr      <= 24'h0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            loaded_words <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            state        <= state_n;
            len_hi       <= len_hi_n;
            len          <= len_n;
            ptr          <= ptr_n;
            byte_idx     <= byte_idx_n;
            word_sr      <= word_sr_n;
            cpu_hold     <= cpu_hold_n;
            load_done    <= load_done_n;
            load_error   <= load_error_n;
            loaded_words <= loaded_words_n;
`ifdef IMEM_CHECKSUM_EN
            csum         <= csum_n;
`endif
        end
    end

    // Next-state, datapath and memory-write decode
    always_comb begin
        state_n        = state;
        len_hi_n       = len_hi;
        len_n          = len;
        ptr_n          = ptr;
        byte_idx_n     = byte_idx;
        word_sr_n      = word_sr;
        cpu_hold_n     = cpu_hold;
        load_done_n    = 1'b0;
        load_error_n   = load_error;
        loaded_words_n = loaded_words;
`ifdef IMEM_CHECKSUM_EN
        csum_n         = csum;
`endif
        mem_we         = 1'b0;
        mem_waddr      = ptr[ADDR_WIDTH-1:0];
        mem_wdata      = {word_sr, rx_data};

        case (state)
            // DONE lasts one cycle but still accepts a new SYNC byte
            S_IDLE, S_DONE: begin
                if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_n        = S_LEN_HI;
                    cpu_hold_n     = 1'b1;
                    load_error_n   = 1'b0;
                    loaded_words_n = '0;
                    ptr_n          = '0;
                    byte_idx_n     = 2'd0;
`ifdef IMEM_CHECKSUM_EN
                    csum_n         = 8'h00;
`endif
                end
            end

            S_LEN_HI: begin
                if (rx_valid) begin
                    len_hi_n = rx_data;
                    state_n  = S_LEN_LO;
                end
            end

            // Full-width length check; oversize keeps the CPU held
            S_LEN_LO: begin
                if (rx_valid) begin
                    if ({1'b0, frame_len} > DEPTH_W) begin
                        load_error_n = 1'b1;
                        state_n      = S_IDLE;
                    end else begin
                        len_n      = PW'(frame_len);
                        ptr_n      = '0;
                        byte_idx_n = 2'd0;
                        if (frame_len == 16'h0000) begin
`ifdef IMEM_CHECKSUM_EN
                            state_n        = S_CHECK;
`else
                            state_n        = S_DONE;
                            load_done_n    = 1'b1;
                            cpu_hold_n     = 1'b0;
                            loaded_words_n = '0;
`endif
                        end else begin
                            state_n = S_DATA;
                        end
                    end
                end
            end

            // Big-endian assembly; 4th byte writes on the same edge
            S_DATA: begin
                if (rx_valid) begin
`ifdef IMEM_CHECKSUM_EN
                    csum_n = csum ^ rx_data;
`endif
                    if (byte_idx == 2'd3) begin
                        mem_we     = 1'b1;
                        ptr_n      = ptr_inc;
                        byte_idx_n = 2'd0;
                        if (ptr_inc == len) begin
`ifdef IMEM_CHECKSUM_EN
                            state_n        = S_CHECK;
`else
                            state_n        = S_DONE;
                            load_done_n    = 1'b1;
                            cpu_hold_n     = 1'b0;
                            loaded_words_n = len;
`endif
                        end
                    end else begin
                        word_sr_n  = {word_sr[15:0], rx_data};
                        byte_idx_n = byte_idx + 2'd1;
                    end
                end
            end

`ifdef IMEM_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_n        = S_DONE;
                        load_done_n    = 1'b1;
                        cpu_hold_n     = 1'b0;
                        loaded_words_n = len;
                    end else begin
                        load_error_n = 1'b1;
                        state_n      = S_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Instruction storage; contents intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read port gated by hold and loaded_words so stale words never leak
    assign rd_idx = Address[ADDR_WIDTH+1:2];
    assign Instruction = (!cpu_hold && ({1'b0, rd_idx} < loaded_words))
                         ? mem[rd_idx] : 32'h0000_0000;

    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed self-checking bench for instruction_ram_loader (ADDR_WIDTH=8).
module tb_instruction_ram_loader;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst_n;
    logic [31:0]   Address;
    logic [31:0]   Instruction;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   loaded_words;

    int errors;
    int checks;
    int done_cnt;

    instruction_ram_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .Address      (Address),
        .Instruction  (Instruction),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .loaded_words (loaded_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        #1;
        check(tag, Instruction, exp);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] basic [11];
    logic [7:0] three [15];
    int d0;

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        Address  = 32'h0;
        basic = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h20, 8'h26};
        three = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        @(negedge clk);
        apply_reset();

        // Reset with no load
        check("rst_hold", 32'(cpu_hold), 32'h1);
        check("rst_done", 32'(load_done), 32'h0);
        check("rst_err", 32'(load_error), 32'h0);
        check("rst_words", 32'(loaded_words), 32'h0);
        rd("rst_rd0", 32'h0, 32'h0);
        rd("rst_rd4", 32'h4, 32'h0);
        rd("rst_rd3fc", 32'h3FC, 32'h0);

        // Basic load, back-to-back
        d0 = done_cnt;
        for (int i = 0; i < 11; i++) begin
            if (i == 7) begin
                check("mid_hold", 32'(cpu_hold), 32'h1);
                rd("mid_rd0", 32'h0, 32'h0);
            end
            send_byte(basic[i], 0);
        end
`ifdef IMEM_CHECKSUM_EN
        send_byte(8'h27, 0);
`endif
        check("basic_done_pulse", 32'(load_done), 32'h1);
        check("basic_hold", 32'(cpu_hold), 32'h0);
        check("basic_words", 32'(loaded_words), 32'h2);
        rd("basic_rd0", 32'h0, 32'h2004_0005);
        rd("basic_rd4", 32'h4, 32'h0000_2026);
        rd("basic_rd8", 32'h8, 32'h0);
        rd("basic_rd_hi_ignored", 32'hFFFF_FC04, 32'h0000_2026);
        @(negedge clk);
        check("basic_done_low", 32'(load_done), 32'h0);
        check("basic_done_cnt", 32'(done_cnt - d0), 32'h1);

        // Oversize frame: N=257 > DEPTH=256
        d0 = done_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        check("over_err", 32'(load_error), 32'h1);
        check("over_hold", 32'(cpu_hold), 32'h1);
        check("over_words", 32'(loaded_words), 32'h0);
        check("over_no_done", 32'(done_cnt - d0), 32'h0);
        rd("over_rd0", 32'h0, 32'h0);

        // SYNC clears the sticky error; 3-word frame with SYNC bytes inside data
        send_byte(three[0], 0);
        check("sync_clr_err", 32'(load_error), 32'h0);
        for (int i = 1; i < 15; i++) send_byte(three[i], 0);
`ifdef IMEM_CHECKSUM_EN
        send_byte(8'h66, 0);
`endif
        check("three_words", 32'(loaded_words), 32'h3);
        check("three_hold", 32'(cpu_hold), 32'h0);
        rd("three_rd0", 32'h0, 32'h1122_3344);
        rd("three_rd4", 32'h4, 32'hA5A5_A5A5);
        rd("three_rd8", 32'h8, 32'hDEAD_BEEF);
        rd("three_rdc", 32'hC, 32'h0);

        // Noise then basic frame with 0..20 cycle gaps; stale word 2 must read 0
        d0 = done_cnt;
        send_byte(8'h00, 3);
        send_byte(8'hFF, 1);
        for (int i = 0; i < 11; i++) send_byte(basic[i], (i * 7) % 21);
`ifdef IMEM_CHECKSUM_EN
        send_byte(8'h27, 0);
`endif
        check("gap_done_cnt", 32'(done_cnt - d0), 32'h1);
        check("gap_words", 32'(loaded_words), 32'h2);
        check("gap_hold", 32'(cpu_hold), 32'h0);
        rd("gap_rd0", 32'h0, 32'h2004_0005);
        rd("gap_rd4", 32'h4, 32'h0000_2026);
        rd("gap_rd8_stale", 32'h8, 32'h0);

        // Reset after 6 data bytes
        for (int i = 0; i < 9; i++) send_byte(basic[i], 0);
        apply_reset();
        check("mrst_hold", 32'(cpu_hold), 32'h1);
        check("mrst_done", 32'(load_done), 32'h0);
        check("mrst_err", 32'(load_error), 32'h0);
        check("mrst_words", 32'(loaded_words), 32'h0);
        rd("mrst_rd0", 32'h0, 32'h0);

        // Zero-length frame completes with nothing loaded
        d0 = done_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        check("zero_done", 32'(load_done), 32'h1);
        check("zero_hold", 32'(cpu_hold), 32'h0);
        check("zero_words", 32'(loaded_words), 32'h0);
        rd("zero_rd0", 32'h0, 32'h0);
        @(negedge clk);

`ifdef IMEM_CHECKSUM_EN
        // Bad checksum: correct value is 01^02^03^04 = 04, send FB
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'hFB, 0);
        @(negedge clk);
        check("csum_err", 32'(load_error), 32'h1);
        check("csum_words", 32'(loaded_words), 32'h0);
        check("csum_hold", 32'(cpu_hold), 32'h1);
        rd("csum_rd0", 32'h0, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_ram_loader.md
# instruction_ram_loader

- Parametrised, UART-loadable instruction memory for the 5-stage MIPS pipeline; replaces the fixed instruction ROM in the IF stage.
- Keeps a combinational read port addressed by the byte PC.
- Adds a sequential boot loader that assembles a framed byte stream from the UART receiver into 32-bit words and writes them from word 0 upward.
- Holds the CPU while a load is in progress.

## Interface
- ADDR_WIDTH, 8: word-address bits; DEPTH = 2**ADDR_WIDTH words; legal range 2..16.
- SYNC_BYTE, 8'hA5: frame start byte.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte PC from IF stage; word index = Address[ADDR_WIDTH+1:2].
- Instruction  output  32  combinational instruction word.
- rx_data  input  8  received byte from UART receiver.
- rx_valid  input  1  one-cycle strobe, rx_data valid; may be back-to-back.
- cpu_hold  output  1  high = pipeline must stall, PC must not advance.
- load_done  output  1  one-cycle pulse on successful load completion.
- load_error  output  1  sticky error flag.
- loaded_words  output  ADDR_WIDTH+1  word count of the last successful load.

## Operation
- **Frame format:** SYNC_BYTE, LEN_HI, LEN_LO, then N = {LEN_HI,LEN_LO} words of 4 bytes each. Words are big-endian: the first byte goes to bits 31:24. With IMEM_CHECKSUM_EN, one checksum byte follows the data.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, CHECK (macro only), DONE.
- **IDLE:**
  - A byte equal to SYNC_BYTE moves to LEN_HI, sets cpu_hold=1, clears load_error and clears loaded_words to 0.
  - Any other byte is ignored.
- **LEN_HI → LEN_LO → length check:** each state advances on rx_valid. Once LEN_LO is captured:
  - N > DEPTH: set load_error=1 and return to IDLE; cpu_hold stays 1.
  - N == 0: go to CHECK (macro on) or DONE (macro off).
  - Otherwise go to DATA with word pointer = 0 and byte index = 0.
- **DATA:**
  - Each rx_valid shifts the byte into the word assembler.
  - On the 4th byte, write the word to mem[pointer] on that same edge, then increment the pointer.
  - After word N-1 is written, go to CHECK or DONE.
- **DONE** (exactly one cycle): load_done=1, loaded_words=N, cpu_hold=0, then go to IDLE.
- **Read rule:** Instruction = mem[index] only when cpu_hold==0 and index < loaded_words. Otherwise Instruction = 32'h0 (nop).
- Memory array contents are not reset. The loaded_words gating guarantees no stale words are ever returned.
- A SYNC_BYTE received outside IDLE is treated as data or length; no resync.

## Timing
- **Reset values:** state=IDLE, cpu_hold=1, load_done=0, load_error=0, loaded_words=0, pointer=0, byte index=0.
- Reset mid-load aborts the load with the same values; the CPU stays held until a complete frame is received.
- **Read latency:** zero cycles (combinational from Address and registered state).
- Word write takes effect on the edge sampling the 4th byte.
- cpu_hold falls on the edge after the last frame byte; load_done is high for that same cycle only.
- One byte is accepted per rx_valid cycle. No backpressure: the loader must accept a byte in every state on every cycle.
- **Width rules:**
  - The 16-bit N is compared against DEPTH at full width.
  - The pointer is ADDR_WIDTH+1 bits and never wraps, since N ≤ DEPTH.
  - Address bits above ADDR_WIDTH+1 are ignored.

## Configuration
- **IMEM_CHECKSUM_EN defined:**
  - The frame carries a trailing byte equal to the XOR of all 4N data bytes; for N=0 the checksum is 8'h00.
  - CHECK compares it against the running XOR.
  - Match: go to DONE.
  - Mismatch: load_error=1, loaded_words stays 0, cpu_hold stays 1, return to IDLE.
- **IMEM_CHECKSUM_EN undefined:** no CHECK state and no checksum byte; DONE follows the last data byte directly.

## Test plan
- **Reset with no load:** after reset release → cpu_hold=1, Instruction=0 for Address 0x0, 0x4, 0x3FC.
- **Basic load:** send A5 00 02 20 04 00 05 00 00 20 26 (+checksum 0x27 with macro) back-to-back → load_done pulses once, loaded_words=2, cpu_hold=0. Expected reads:
  - Address 0x0 → 32'h20040005
  - Address 0x4 → 32'h00002026
  - Address 0x8 → 0
- **Oversize frame:** ADDR_WIDTH=8, send A5 01 01 → load_error=1, cpu_hold=1, no load_done. A subsequent valid frame clears load_error and loads.
- **Noise and gaps:** bytes 00 FF before A5 are ignored; idle gaps between bytes of 0–20 cycles → same result as the basic load.
- **Reset mid-frame:** assert reset after 6 data bytes → all outputs return to reset values; Instruction=0 at Address 0x0.
- **Macro on, bad checksum:** valid 1-word frame with checksum byte flipped → load_error=1, loaded_words=0, cpu_hold=1.
